// File: rtl/mem_arbiter_if.sv
// Line-transfer memory port: command, write-beat and read-response channels.
// A requester drives the master side; the memory (or an arbiter) sits on the slave side.
interface mem_arbiter_if #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128
);
  logic                       req_valid;
  logic                       req_ready;
  logic [MEM_ADDR_BITS-1:0]   req_addr;
  logic                       req_rw;
  logic                       req_data_valid;
  logic                       req_data_ready;
  logic [MEM_DATA_BITS-1:0]   req_data_bits;
  logic [MEM_DATA_BITS/8-1:0] req_data_mask;
  logic                       resp_valid;
  logic [MEM_DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) round-robin arbiter in front of a single line-transfer
// memory port; one whole line transaction (command plus BEATS beats) owns the memory at a time.
module mem_arbiter #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128,
  parameter int BEATS         = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             owner_dc;
  logic             prio_dc;
  logic [CNT_W-1:0] beat_cnt;

  logic in_idle;
  logic in_rd;
  logic in_wr;
  logic grant_ic;
  logic grant_dc;
  logic cmd_fire;
  logic wr_fire;
  logic rd_fire;
  logic last_beat;

  logic [MEM_ADDR_BITS-1:0]   sel_addr;
  logic                       sel_rw;
  logic                       sel_data_valid;
  logic [MEM_DATA_BITS-1:0]   sel_data_bits;
  logic [MEM_DATA_BITS/8-1:0] sel_data_mask;

  // Reset also gates the decoded state so every valid/ready drops the instant it asserts.
  assign in_idle = (state == IDLE) & ~reset;
  assign in_rd   = (state == RD)   & ~reset;
  assign in_wr   = (state == WR)   & ~reset;

  assign grant_dc = in_idle & dc.req_valid & (~ic.req_valid |  prio_dc);
  assign grant_ic = in_idle & ic.req_valid & (~dc.req_valid | ~prio_dc);

  always_comb begin
    sel_addr = ic.req_addr;
    sel_rw   = ic.req_rw;
    if (grant_dc) begin
      sel_addr = dc.req_addr;
      sel_rw   = dc.req_rw;
    end
  end

  always_comb begin
    sel_data_valid = ic.req_data_valid;
    sel_data_bits  = ic.req_data_bits;
    sel_data_mask  = ic.req_data_mask;
    if (owner_dc) begin
      sel_data_valid = dc.req_data_valid;
      sel_data_bits  = dc.req_data_bits;
      sel_data_mask  = dc.req_data_mask;
    end
  end

  assign mem.req_valid = grant_ic | grant_dc;
  assign mem.req_addr  = sel_addr;
  assign mem.req_rw    = sel_rw;
  assign ic.req_ready  = grant_ic & mem.req_ready;
  assign dc.req_ready  = grant_dc & mem.req_ready;
  assign cmd_fire      = mem.req_valid & mem.req_ready;

  assign mem.req_data_valid = in_wr & sel_data_valid;
  assign mem.req_data_bits  = sel_data_bits;
  assign mem.req_data_mask  = sel_data_mask;
  assign ic.req_data_ready  = in_wr & ~owner_dc & mem.req_data_ready;
  assign dc.req_data_ready  = in_wr &  owner_dc & mem.req_data_ready;
  assign wr_fire            = mem.req_data_valid & mem.req_data_ready;

  // Responses arriving while no read is outstanding are silently discarded.
  assign rd_fire       = in_rd & mem.resp_valid;
  assign ic.resp_valid = rd_fire & ~owner_dc;
  assign dc.resp_valid = rd_fire &  owner_dc;
  assign ic.resp_data  = mem.resp_data;
  assign dc.resp_data  = mem.resp_data;

  assign last_beat = (beat_cnt == LAST_BEAT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd_fire) state_next = sel_rw ? WR : RD;
      RD:   if (rd_fire && last_beat) state_next = IDLE;
      WR:   if (wr_fire && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The priority pointer moves only on an accepted command, so a requester that
  // withdraws before the handshake does not cost the other port its turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner_dc <= 1'b0;
      prio_dc  <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      if (cmd_fire) begin
        owner_dc <= grant_dc;
        prio_dc  <= grant_ic;
        beat_cnt <= '0;
      end else if (wr_fire || rd_fire) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands, write beats and read beats
// are queued as stimulus is driven and compared as the arbiter presents them.
module tb_mem_arbiter;

  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int MW    = DW / 8;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW)) ic_bus ();
  mem_arbiter_if #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW)) dc_bus ();
  mem_arbiter_if #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW)) mem_bus ();

  mem_arbiter #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .BEATS(BEATS)) dut (
    .clk   (clk),
    .reset (reset),
    .ic    (ic_bus),
    .dc    (dc_bus),
    .mem   (mem_bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [159:0] cmd_q[$];
  logic [159:0] wr_q[$];
  logic [159:0] ic_q[$];
  logic [159:0] dc_q[$];
  logic [159:0] mon_exp;

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] handshake_outs();
    return {ic_bus.req_ready, dc_bus.req_ready, ic_bus.req_data_ready, dc_bus.req_data_ready,
            ic_bus.resp_valid, dc_bus.resp_valid, mem_bus.req_valid, mem_bus.req_data_valid};
  endfunction

  function automatic void push_cmd(input bit is_dc, input logic [AW-1:0] addr, input bit rw);
    cmd_q.push_back(160'({is_dc, ~is_dc, rw, addr}));
  endfunction

  function automatic void push_rd(input bit is_dc, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_dc) dc_q.push_back(160'({1'b0, base + DW'(i)}));
      else       ic_q.push_back(160'({1'b0, base + DW'(i)}));
    end
  endfunction

  // Pops the matching expectation whenever the arbiter completes a transfer; an
  // empty queue yields an all-ones expectation that no real observation can match.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_bus.req_valid && mem_bus.req_ready) begin
        mon_exp = (cmd_q.size() != 0) ? cmd_q.pop_front() : '1;
        checkOutput("cmd", 160'({dc_bus.req_ready, ic_bus.req_ready, mem_bus.req_rw,
                                 mem_bus.req_addr}), mon_exp);
      end
      if (mem_bus.req_data_valid && mem_bus.req_data_ready) begin
        mon_exp = (wr_q.size() != 0) ? wr_q.pop_front() : '1;
        checkOutput("wr_beat", 160'({dc_bus.req_data_ready, ic_bus.req_data_ready,
                                     mem_bus.req_data_mask, mem_bus.req_data_bits}), mon_exp);
      end
      if (ic_bus.resp_valid) begin
        mon_exp = (ic_q.size() != 0) ? ic_q.pop_front() : '1;
        checkOutput("ic_resp", 160'({dc_bus.resp_valid, ic_bus.resp_data}), mon_exp);
      end
      if (dc_bus.resp_valid) begin
        mon_exp = (dc_q.size() != 0) ? dc_q.pop_front() : '1;
        checkOutput("dc_resp", 160'({ic_bus.resp_valid, dc_bus.resp_data}), mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit is_dc, input bit valid, input logic [AW-1:0] addr,
                               input bit rw);
    if (is_dc) begin
      dc_bus.req_valid = valid;
      dc_bus.req_addr  = addr;
      dc_bus.req_rw    = rw;
    end else begin
      ic_bus.req_valid = valid;
      ic_bus.req_addr  = addr;
      ic_bus.req_rw    = rw;
    end
  endtask

  // Returns just after the clock edge on which the port's command was accepted.
  task automatic wait_grant(input bit is_dc, input string tag);
    bit granted = 1'b0;
    for (int c = 0; c < 30 && !granted; c++) begin
      @(negedge clk);
      granted = is_dc ? dc_bus.req_ready : ic_bus.req_ready;
      tick();
    end
    checkOutput(tag, 160'(granted), 160'(1));
  endtask

  task automatic rd_beats(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem_bus.resp_valid = 1'b1;
      mem_bus.resp_data  = base + DW'(i);
      @(negedge clk);
      checkOutput("no_cmd_in_rd", 160'(mem_bus.req_valid), 160'(0));
      tick();
    end
    mem_bus.resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int nb;
    bit fire;
    bit on;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    ic_bus.req_data_valid  = 1'b0;
    ic_bus.req_data_bits   = '0;
    ic_bus.req_data_mask   = '0;
    dc_bus.req_data_valid  = 1'b0;
    dc_bus.req_data_bits   = '0;
    dc_bus.req_data_mask   = '0;
    mem_bus.req_ready      = 1'b1;
    mem_bus.req_data_ready = 1'b0;
    mem_bus.resp_valid     = 1'b0;
    mem_bus.resp_data      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", 160'(handshake_outs()), 160'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_outputs", 160'(handshake_outs()), 160'(0));
    tick();

    // Simultaneous reads: dc wins the first tie, ic follows once dc's line is done.
    push_cmd(1'b1, AW'('h20), 1'b0);
    push_cmd(1'b0, AW'('h10), 1'b0);
    push_rd(1'b1, DW'('hD000), BEATS);
    push_rd(1'b0, DW'('h1000), BEATS);
    applyStimulus(1'b0, 1'b1, AW'('h10), 1'b0);
    applyStimulus(1'b1, 1'b1, AW'('h20), 1'b0);
    wait_grant(1'b1, "t1_dc_grant");
    dc_bus.req_valid = 1'b0;
    rd_beats(DW'('hD000), BEATS);
    wait_grant(1'b0, "t1_ic_grant");
    ic_bus.req_valid = 1'b0;
    rd_beats(DW'('h1000), BEATS);

    // dc line write with the memory accepting beats only every other cycle.
    push_cmd(1'b1, AW'('h5), 1'b1);
    for (int i = 0; i < BEATS; i++)
      wr_q.push_back(160'({2'b10, MW'(16'hFFFF >> (4 * i)), DW'('hA + i)}));
    applyStimulus(1'b1, 1'b1, AW'('h5), 1'b1);
    wait_grant(1'b1, "t2_dc_grant");
    dc_bus.req_valid = 1'b0;
    k = 0;
    mem_bus.req_data_ready = 1'b1;
    dc_bus.req_data_valid  = 1'b1;
    dc_bus.req_data_bits   = DW'('hA);
    dc_bus.req_data_mask   = MW'(16'hFFFF);
    for (int c = 0; c < 40 && k < BEATS; c++) begin
      @(negedge clk);
      fire = dc_bus.req_data_ready;
      tick();
      if (fire) k++;
      mem_bus.req_data_ready = ~mem_bus.req_data_ready;
      dc_bus.req_data_bits   = DW'('hA + k);
      dc_bus.req_data_mask   = MW'(16'hFFFF >> (4 * k));
    end
    checkOutput("t2_beats_accepted", 160'(k), 160'(BEATS));
    mem_bus.req_data_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_idle_after_last", 160'({mem_bus.req_data_valid, dc_bus.req_data_ready}),
                160'(0));
    tick();
    dc_bus.req_data_valid = 1'b0;

    // ic read with gaps in the response stream.
    push_cmd(1'b0, AW'('h33), 1'b0);
    push_rd(1'b0, DW'('h3000), BEATS);
    applyStimulus(1'b0, 1'b1, AW'('h33), 1'b0);
    wait_grant(1'b0, "t3_ic_grant");
    ic_bus.req_valid = 1'b0;
    nb = 0;
    for (int c = 1; c <= 10; c++) begin
      on = (c == 3) || (c == 5) || (c == 9) || (c == 10);
      mem_bus.resp_valid = on;
      mem_bus.resp_data  = DW'('h3000 + nb);
      @(negedge clk);
      checkOutput("t3_resp_valid", 160'({dc_bus.resp_valid, ic_bus.resp_valid}),
                  160'({1'b0, on}));
      tick();
      if (on) nb++;
    end
    mem_bus.resp_valid = 1'b0;

    // dc re-requests back to back while ic keeps waiting: dc, ic, dc.
    push_cmd(1'b1, AW'('h40), 1'b0);
    push_cmd(1'b0, AW'('h30), 1'b0);
    push_cmd(1'b1, AW'('h41), 1'b0);
    push_rd(1'b1, DW'('h4000), BEATS);
    push_rd(1'b0, DW'('h3100), BEATS);
    push_rd(1'b1, DW'('h4100), BEATS);
    applyStimulus(1'b0, 1'b1, AW'('h30), 1'b0);
    applyStimulus(1'b1, 1'b1, AW'('h40), 1'b0);
    wait_grant(1'b1, "t4_dc_grant_a");
    dc_bus.req_addr = AW'('h41);
    rd_beats(DW'('h4000), BEATS);
    wait_grant(1'b0, "t4_ic_grant");
    ic_bus.req_valid = 1'b0;
    rd_beats(DW'('h3100), BEATS);
    wait_grant(1'b1, "t4_dc_grant_b");
    dc_bus.req_valid = 1'b0;
    rd_beats(DW'('h4100), BEATS);

    // Stray responses while idle must vanish and leave the arbiter idle.
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp_data  = DW'('hBAD);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("t5_stray_dropped", 160'({ic_bus.resp_valid, dc_bus.resp_valid}), 160'(0));
      tick();
    end
    mem_bus.resp_valid = 1'b0;
    push_cmd(1'b1, AW'('h50), 1'b0);
    push_rd(1'b1, DW'('h5000), BEATS);
    applyStimulus(1'b1, 1'b1, AW'('h50), 1'b0);
    wait_grant(1'b1, "t5_dc_grant");
    dc_bus.req_valid = 1'b0;
    rd_beats(DW'('h5000), BEATS);

    // Reset during the second beat of a dc read; the pointer must favour dc again after.
    push_cmd(1'b1, AW'('h60), 1'b0);
    push_rd(1'b1, DW'('h6000), 1);
    applyStimulus(1'b1, 1'b1, AW'('h60), 1'b0);
    wait_grant(1'b1, "t6_dc_grant");
    dc_bus.req_valid = 1'b0;
    rd_beats(DW'('h6000), 1);
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp_data  = DW'('h6001);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, AW'('h70), 1'b0);
    applyStimulus(1'b1, 1'b1, AW'('h71), 1'b0);
    #1;
    checkOutput("t6_reset_immediate", 160'(handshake_outs()), 160'(0));
    @(negedge clk);
    checkOutput("t6_reset_held", 160'(handshake_outs()), 160'(0));
    push_cmd(1'b1, AW'('h71), 1'b0);
    push_cmd(1'b0, AW'('h70), 1'b0);
    push_rd(1'b1, DW'('h7100), BEATS);
    push_rd(1'b0, DW'('h7000), BEATS);
    tick();
    reset = 1'b0;
    mem_bus.resp_valid = 1'b0;
    wait_grant(1'b1, "t6_dc_grant_after");
    dc_bus.req_valid = 1'b0;
    rd_beats(DW'('h7100), BEATS);
    wait_grant(1'b0, "t6_ic_grant_after");
    ic_bus.req_valid = 1'b0;
    rd_beats(DW'('h7000), BEATS);

    repeat (2) tick();
    checkOutput("cmd_q_drained", 160'(cmd_q.size()), 160'(0));
    checkOutput("wr_q_drained", 160'(wr_q.size()), 160'(0));
    checkOutput("ic_q_drained", 160'(ic_q.size()), 160'(0));
    checkOutput("dc_q_drained", 160'(dc_q.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
